// File: rtl/diff_sq_csr.sv
// diff_sq_csr: Avalon-MM control/status front end for an (A+B)*(A-B)
// compute stage. Holds operands A/B and drives them on coe_A/coe_B. On START
// it waits the stage's fixed latency, then captures coe_R into RESULT and
// raises DONE (and IRQ when enabled). It also counts completed operations.
module diff_sq_csr #(
  parameter int N       = 32,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic         csi_clk,
  input  logic         rsi_srst,
  input  logic [1:0]   avs_s0_address,
  input  logic         avs_s0_write,
  input  logic [N-1:0] avs_s0_writedata,
  input  logic         avs_s0_read,
  output logic [N-1:0] avs_s0_readdata,
  output logic         ins_irq,
  output logic [N-1:0] coe_A,
  output logic [N-1:0] coe_B,
  input  logic [N-1:0] coe_R
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Register map
  localparam logic [1:0] ADDR_A      = 2'd0;
  localparam logic [1:0] ADDR_B      = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  // Latency countdown must be able to hold LATENCY itself
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  // Architectural state
  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [N-1:0]     reg_a_r;
  logic [N-1:0]     reg_b_r;
  logic [N-1:0]     result_r;
  logic [CNT_W-1:0] op_cnt_r;
  logic             irq_en_r;
  logic             done_r;
  logic [N-1:0]     readdata_r;

  // Decoded controls
  logic             busy_s;
  logic             wr_a_s;
  logic             wr_b_s;
  logic             wr_ctrl_s;
  logic             start_s;
  logic             clr_s;
  logic             capture_s;
  logic             rd_en_s;
  logic [1:0]       state_nx_s;
  logic [N-1:0]     status_s;
  logic [N-1:0]     rd_mux_s;

  // Decode bus strobes; operand and START/CLR writes are locked out while busy
  always_comb begin
    busy_s    = (state_r == ST_BUSY);
    wr_a_s    = avs_s0_write && (avs_s0_address == ADDR_A) && !busy_s;
    wr_b_s    = avs_s0_write && (avs_s0_address == ADDR_B) && !busy_s;
    wr_ctrl_s = avs_s0_write && (avs_s0_address == ADDR_CTRL);
    start_s   = wr_ctrl_s && avs_s0_writedata[0] && !busy_s;
    // START has priority over CLR when both are set
    clr_s     = wr_ctrl_s && avs_s0_writedata[1] && !avs_s0_writedata[0] && !busy_s;
    capture_s = busy_s && (cnt_r == CW'(1));
    // A write in the same cycle suppresses the read
    rd_en_s   = avs_s0_read && !avs_s0_write;
  end

  // Next-state logic for the IDLE/BUSY/DONE sequencer
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nx_s = ST_BUSY;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (capture_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (start_s) begin
          state_nx_s = ST_BUSY;
        end else if (clr_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge csi_clk) begin
    if (rsi_srst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Latency countdown: loaded on START, runs down to zero while busy
  always_ff @(posedge csi_clk) begin
    if (rsi_srst) begin
      cnt_r <= '0;
    end else if (start_s) begin
      cnt_r <= CW'(LATENCY);
    end else if (busy_s && (cnt_r != '0)) begin
      cnt_r <= cnt_r - CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Operand registers, held stable for the whole operation
  always_ff @(posedge csi_clk) begin
    if (rsi_srst) begin
      reg_a_r <= '0;
      reg_b_r <= '0;
    end else begin
      if (wr_a_s) begin
        reg_a_r <= avs_s0_writedata;
      end else begin
        reg_a_r <= reg_a_r;
      end
      if (wr_b_s) begin
        reg_b_r <= avs_s0_writedata;
      end else begin
        reg_b_r <= reg_b_r;
      end
    end
  end

  // Interrupt enable is taken from every CTRL write, even while busy
  always_ff @(posedge csi_clk) begin
    if (rsi_srst) begin
      irq_en_r <= 1'b0;
    end else if (wr_ctrl_s) begin
      irq_en_r <= avs_s0_writedata[2];
    end else begin
      irq_en_r <= irq_en_r;
    end
  end

  // Done flag: cleared by START or CLR, set when the result is captured
  always_ff @(posedge csi_clk) begin
    if (rsi_srst) begin
      done_r <= 1'b0;
    end else if (start_s || clr_s) begin
      done_r <= 1'b0;
    end else if (capture_s) begin
      done_r <= 1'b1;
    end else begin
      done_r <= done_r;
    end
  end

  // Capture the compute-stage result verbatim and count the completion
  always_ff @(posedge csi_clk) begin
    if (rsi_srst) begin
      result_r <= '0;
      op_cnt_r <= '0;
    end else if (capture_s) begin
      result_r <= coe_R;
      op_cnt_r <= op_cnt_r + CNT_W'(1);
    end else begin
      result_r <= result_r;
      op_cnt_r <= op_cnt_r;
    end
  end

  // Assemble the STATUS word: busy, done, irq_en, op_cnt at bit 16
  always_comb begin
    status_s              = '0;
    status_s[0]           = busy_s;
    status_s[1]           = done_r;
    status_s[2]           = irq_en_r;
    status_s[16 +: CNT_W] = op_cnt_r;
  end

  // Read data multiplexer
  always_comb begin
    rd_mux_s = '0;
    case (avs_s0_address)
      ADDR_A:      rd_mux_s = reg_a_r;
      ADDR_B:      rd_mux_s = reg_b_r;
      ADDR_CTRL:   rd_mux_s = status_s;
      ADDR_RESULT: rd_mux_s = result_r;
      default:     rd_mux_s = '0;
    endcase
  end

  // Registered read data, one-cycle latency, held between reads
  always_ff @(posedge csi_clk) begin
    if (rsi_srst) begin
      readdata_r <= '0;
    end else if (rd_en_s) begin
      readdata_r <= rd_mux_s;
    end else begin
      readdata_r <= readdata_r;
    end
  end

  assign avs_s0_readdata = readdata_r;
  assign coe_A           = reg_a_r;
  assign coe_B           = reg_b_r;
  assign ins_irq         = done_r & irq_en_r;

endmodule

// File: tb/tb_diff_sq_csr.sv
// Testbench for diff_sq_csr. Directed register accesses; every read pushes
// its hand-computed expected value into a scoreboard queue, and a monitor
// pops and compares when the registered read data appears. A second
// instance built with CNT_W=2 shares the bus to exercise counter wrap.
module tb_diff_sq_csr;

  logic        clk;
  logic        srst;
  logic [1:0]  address;
  logic        write;
  logic [31:0] wdata;
  logic        read;
  logic [31:0] rdata;
  logic        irq;
  logic [31:0] coe_a;
  logic [31:0] coe_b;
  logic [31:0] coe_r;
  logic [31:0] p1;
  logic [31:0] rdata2;
  logic        irq2;
  logic [31:0] coe_a2;
  logic [31:0] coe_b2;

  int checks;
  int failures;

  logic [31:0] exp_q[$];
  logic [31:0] exp2_q[$];
  string       name_q[$];

  diff_sq_csr #(.N(32), .LATENCY(2), .CNT_W(16)) dut (
    .csi_clk(clk), .rsi_srst(srst),
    .avs_s0_address(address), .avs_s0_write(write),
    .avs_s0_writedata(wdata), .avs_s0_read(read),
    .avs_s0_readdata(rdata), .ins_irq(irq),
    .coe_A(coe_a), .coe_B(coe_b), .coe_R(coe_r)
  );

  diff_sq_csr #(.N(32), .LATENCY(2), .CNT_W(2)) dut2 (
    .csi_clk(clk), .rsi_srst(srst),
    .avs_s0_address(address), .avs_s0_write(write),
    .avs_s0_writedata(wdata), .avs_s0_read(read),
    .avs_s0_readdata(rdata2), .ins_irq(irq2),
    .coe_A(coe_a2), .coe_B(coe_b2), .coe_R(coe_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage model of the compute stage: (A+B)*(A-B), two clocks latency
  always @(posedge clk) begin
    if (srst) begin
      p1    <= 32'h0;
      coe_r <= 32'h0;
    end else begin
      p1    <= (coe_a + coe_b) * (coe_a - coe_b);
      coe_r <= p1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a;
    wdata   = d;
    write   = 1'b1;
    @(posedge clk);
    #1;
    write   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input logic [31:0] e2,
                    input string nm);
    exp_q.push_back(e);
    exp2_q.push_back(e2);
    name_q.push_back(nm);
    address = a;
    read    = 1'b1;
    @(posedge clk);
    #1;
    read    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: a read sampled on an edge presents its data just after that edge
  initial begin
    string nm;
    forever begin
      @(posedge clk);
      if (read && !write) begin
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected: got 0x%08h expected no read", rdata);
        end else begin
          nm = name_q.pop_front();
          check(nm, rdata, exp_q.pop_front());
          check({nm, "_cnt2"}, rdata2, exp2_q.pop_front());
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    srst     = 1'b1;
    address  = 2'd0;
    write    = 1'b0;
    wdata    = 32'h0;
    read     = 1'b0;

    // 1. Reset
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b0;
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_coe_a", coe_a, 32'h0);
    check("rst_coe_b", coe_b, 32'h0);
    rd(2'd0, 32'h0, 32'h0, "rst_a");
    rd(2'd1, 32'h0, 32'h0, "rst_b");
    rd(2'd2, 32'h0, 32'h0, "rst_status");
    rd(2'd3, 32'h0, 32'h0, "rst_result");

    // 2. Basic op: 7,3 -> 40, busy for exactly two clocks
    wr(2'd0, 32'd7);
    wr(2'd1, 32'd3);
    wr(2'd2, 32'h5);
    rd(2'd2, 32'h0000_0005, 32'h0000_0005, "busy_clk1");
    rd(2'd2, 32'h0000_0005, 32'h0000_0005, "busy_clk2");
    rd(2'd2, 32'h0001_0006, 32'h0001_0006, "basic_status");
    rd(2'd3, 32'd40, 32'd40, "basic_result");
    check("basic_irq", {31'h0, irq}, 32'h1);
    check("basic_coe_a", coe_a, 32'd7);
    check("basic_coe_b", coe_b, 32'd3);

    // 3. Negative wrap and modulo wrap
    wr(2'd0, 32'd3);
    wr(2'd1, 32'd7);
    wr(2'd2, 32'h5);
    idle(3);
    rd(2'd3, 32'hFFFF_FFD8, 32'hFFFF_FFD8, "neg_result");
    rd(2'd2, 32'h0002_0006, 32'h0002_0006, "neg_status");
    wr(2'd0, 32'h0001_0000);
    wr(2'd1, 32'h0);
    wr(2'd2, 32'h5);
    idle(3);
    rd(2'd3, 32'h0, 32'h0, "wrap_result");

    // 4. Busy protection: operand write and second START while busy
    wr(2'd0, 32'd5);
    wr(2'd1, 32'd1);
    wr(2'd2, 32'h5);
    wr(2'd0, 32'd99);
    wr(2'd2, 32'h5);
    rd(2'd0, 32'd5, 32'd5, "busy_a_kept");
    check("busy_coe_a", coe_a, 32'd5);
    rd(2'd2, 32'h0004_0006, 32'h0000_0006, "busy_status");
    rd(2'd3, 32'd24, 32'd24, "busy_result");
    idle(3);
    rd(2'd2, 32'h0004_0006, 32'h0000_0006, "busy_no_restart");

    // 5. Clear, then abort by reset mid-operation
    check("pre_clr_irq", {31'h0, irq}, 32'h1);
    wr(2'd2, 32'h2);
    check("clr_irq", {31'h0, irq}, 32'h0);
    rd(2'd2, 32'h0004_0000, 32'h0000_0000, "clr_status");
    wr(2'd2, 32'h5);
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    rd(2'd2, 32'h0, 32'h0, "abort_status");
    rd(2'd3, 32'h0, 32'h0, "abort_result");
    idle(3);
    rd(2'd2, 32'h0, 32'h0, "abort_no_late");
    check("abort_irq", {31'h0, irq}, 32'h0);
    check("abort_coe_a", coe_a, 32'h0);

    // 6. Five ops: 16-bit counter reads 5, 2-bit counter wraps to 1
    wr(2'd0, 32'd2);
    wr(2'd1, 32'd1);
    for (int i = 0; i < 5; i++) begin
      wr(2'd2, 32'h1);
      idle(3);
    end
    rd(2'd2, 32'h0005_0002, 32'h0001_0002, "wrap_status");
    rd(2'd3, 32'd3, 32'd3, "wrap_op_result");
    check("wrap_irq_off", {31'h0, irq}, 32'h0);

    // Read and write in the same cycle: write lands, readdata holds
    address = 2'd0;
    wdata   = 32'h0000_1234;
    write   = 1'b1;
    read    = 1'b1;
    @(posedge clk);
    #1;
    write   = 1'b0;
    read    = 1'b0;
    check("rdwr_hold", rdata, 32'd3);
    check("rdwr_hold_cnt2", rdata2, 32'd3);
    rd(2'd0, 32'h0000_1234, 32'h0000_1234, "rdwr_applied");

    idle(2);
    check("queue_drained", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
